// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the memory-mapped character-LCD controller.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] dat;
    } lcd_entry_t;

    // o_status bit positions; level occupies four bits starting at STAT_LVL_LSB
    localparam int STAT_BUSY    = 0;
    localparam int STAT_ON      = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_LVL_LSB = 3;
    localparam int STAT_OVF     = 7;

    localparam int CTRL_ON      = 0;
    localparam int CTRL_CLR_OVF = 1;

    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;

    // Clear and home are the only instructions needing the long execution wait
    function automatic logic is_long_cmd(lcd_entry_t e);
        return !e.rs && ((e.dat == LCD_CLEAR) || (e.dat == LCD_HOME));
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command/data FIFO: DEPTH entries of WIDTH bits, power-of-two pointers plus a separate count.
// Latency: a pushed entry is visible on pop_dat one cycle after the push edge.
// Backpressure: push_rdy is low when full unless a pop occurs in the same cycle; pops when empty are ignored.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_acc;
    logic             pop_acc;

    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign pop_acc  = pop_vld && !empty;
    assign push_rdy = !full || pop_acc;
    assign push_acc = push_vld && push_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_acc && !pop_acc)      level <= level + LVL_W'(1);
            else if (!push_acc && pop_acc) level <= level - LVL_W'(1);
        end
    end

    always_ff @(posedge core_clk) begin
        if (push_acc) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD controller: queues stores and sequences RS/DATA/EN with setup, pulse, hold and exec waits.
// Latency: an entry pushed into an idle, empty controller is popped onto RS/DATA on the next edge.
// Backpressure: none toward the CPU; pushes into a full FIFO are dropped and flagged as sticky overflow.
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 12,
    parameter int HOLD_CYC     = 2,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en,
    input  logic        i_wr_sel,
    input  logic [8:0]  i_wr_data,
    output logic [31:0] o_status,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on
);

    localparam int CNT_W = $clog2(CLR_WAIT_CYC + 1);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    lcd_state_e       state;
    lcd_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             en_nxt;
    logic             pop;
    logic             push_vld;
    logic             push_rdy;
    logic             ctrl_wr;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] level;
    logic             ovf;
    lcd_entry_t       head;
    lcd_entry_t       cur;

    assign push_vld = i_wr_en && !i_wr_sel;
    assign ctrl_wr  = i_wr_en && i_wr_sel;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(lcd_entry_t))
    ) u_fifo (
        .core_clk (i_clk),
        .arst_n   (i_reset),
        .push_vld (push_vld),
        .push_rdy (push_rdy),
        .push_dat (i_wr_data),
        .pop_vld  (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt - CNT_W'(1);
        en_nxt    = 1'b0;
        pop       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_nxt = cnt;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_SETUP;
                    cnt_nxt   = CNT_W'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = CNT_W'(PULSE_CYC - 1);
                    en_nxt    = 1'b1;
                end
            end
            ST_PULSE: begin
                en_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = CNT_W'(HOLD_CYC - 1);
                    en_nxt    = 1'b0;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = is_long_cmd(cur) ? CNT_W'(CLR_WAIT_CYC - 1)
                                                 : CNT_W'(CMD_WAIT_CYC - 1);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Reset clears EN asynchronously so a mid-pulse abort never leaves the strobe high
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            o_lcd_en <= 1'b0;
            cur      <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            o_lcd_en <= en_nxt;
            if (pop) cur <= head;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_lcd_on <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (ctrl_wr) o_lcd_on <= i_wr_data[CTRL_ON];
            if (ctrl_wr && i_wr_data[CTRL_CLR_OVF]) ovf <= 1'b0;
            else if (push_vld && !push_rdy)         ovf <= 1'b1;
        end
    end

    assign o_lcd_data = cur.dat;
    assign o_lcd_rs   = cur.rs;
    assign o_lcd_rw   = 1'b0;

    always_comb begin
        o_status                       = '0;
        o_status[STAT_BUSY]            = (state != ST_IDLE) || !fifo_empty;
        o_status[STAT_ON]              = o_lcd_on;
        o_status[STAT_FULL]            = fifo_full;
        o_status[STAT_LVL_LSB +: 4]    = 4'(level);
        o_status[STAT_OVF]             = ovf;
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with short timing parameters and hand-computed cycle expectations.
module tb_lcd_ctrl;
    import lcd_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int HOLD  = 2;
    localparam int CMDW  = 8;
    localparam int CLRW  = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        wr_sel;
    logic [8:0]  wr_data;
    logic [31:0] status;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int         rise_q[$];
    int         fall_q[$];
    logic [8:0] data_q[$];
    logic       en_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_ctrl #(
        .FIFO_DEPTH   (DEPTH),
        .SETUP_CYC    (SETUP),
        .PULSE_CYC    (PULSE),
        .HOLD_CYC     (HOLD),
        .CMD_WAIT_CYC (CMDW),
        .CLR_WAIT_CYC (CLRW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_wr_en    (wr_en),
        .i_wr_sel   (wr_sel),
        .i_wr_data  (wr_data),
        .o_status   (status),
        .o_lcd_data (lcd_data),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_en   (lcd_en),
        .o_lcd_on   (lcd_on)
    );

    // Records the edge number after which EN rose/fell, plus {RS,DATA} seen at each rise
    always @(negedge clk) begin
        if (lcd_en && !en_q) begin
            rise_q.push_back(cyc);
            data_q.push_back({lcd_rs, lcd_data});
        end
        if (!lcd_en && en_q) fall_q.push_back(cyc);
        en_q <= lcd_en;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rs, input logic [7:0] b);
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_data = {rs, b};
        step();
        wr_en   = 1'b0;
    endtask

    task automatic ctrl(input logic [8:0] v);
        wr_en   = 1'b1;
        wr_sel  = 1'b1;
        wr_data = v;
        step();
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
    endtask

    task automatic wait_falls(input int n, input string tag);
        int k = 0;
        while (fall_q.size() < n && k < 400) begin
            step();
            k++;
        end
        check(tag, 32'(fall_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (status[STAT_BUSY] && k < 400) begin
            step();
            k++;
        end
        check(tag, 32'(status[STAT_BUSY]), 32'd0);
    endtask

    function automatic logic [3:0] lvl();
        return status[STAT_LVL_LSB +: 4];
    endfunction

    initial begin
        int n;
        int f;
        int k;
        int nr;
        logic [8:0] exp_q [6];
        exp_q = '{9'h1A0, 9'h1A1, 9'h1A2, 9'h1A3, 9'h1A4, 9'h1A6};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_data = '0;
        repeat (3) step();

        check("rst_data", 32'(lcd_data), 32'h0);
        check("rst_rs",   32'(lcd_rs),   32'h0);
        check("rst_rw",   32'(lcd_rw),   32'h0);
        check("rst_en",   32'(lcd_en),   32'h0);
        check("rst_on",   32'(lcd_on),   32'h0);
        check("rst_status", status, 32'h0);

        rst_n = 1'b1;
        step();
        ctrl(9'h001);
        check("on_pin",    32'(lcd_on), 32'h1);
        check("on_status", status,      32'h2);

        // Single data write: pop one edge after push, EN rises SETUP later, lasts PULSE
        rise_q.delete(); fall_q.delete(); data_q.delete();
        push(1'b1, 8'h41);
        n = cyc;
        check("single_level", 32'(lvl()), 32'd1);
        step();
        check("single_data", 32'(lcd_data), 32'h41);
        check("single_rs",   32'(lcd_rs),   32'h1);
        wait_falls(1, "single_fall_timeout");
        check("single_rise_at", 32'(rise_q[0] - n), 32'(1 + SETUP));
        check("single_pulse",   32'(fall_q[0] - rise_q[0]), 32'(PULSE));
        wait_idle("single_idle_timeout");
        check("single_busy_drop", 32'(cyc - fall_q[0]), 32'(HOLD + CMDW));
        check("single_status_idle", status, 32'h2);

        // Clear instruction uses the long wait before the next entry is popped
        rise_q.delete(); fall_q.delete(); data_q.delete();
        push(1'b0, 8'h01);
        push(1'b1, 8'h42);
        wait_falls(2, "clr_fall_timeout");
        check("clr_gap",   32'(rise_q[1] - fall_q[0]), 32'(HOLD + CLRW + 1 + SETUP));
        check("clr_ent0",  32'(data_q[0]), 32'h001);
        check("clr_ent1",  32'(data_q[1]), 32'h142);
        wait_idle("clr_idle_timeout");

        // Six back-to-back pushes: first popped early, four fill the FIFO, sixth dropped
        rise_q.delete(); fall_q.delete(); data_q.delete();
        for (int i = 0; i < 6; i++) push(1'b1, 8'hA0 + 8'(i));
        check("ovf_level", 32'(lvl()), 32'd4);
        check("ovf_full",  32'(status[STAT_FULL]), 32'h1);
        check("ovf_flag",  32'(status[STAT_OVF]),  32'h1);
        ctrl(9'h002);
        check("ovf_cleared",    32'(status[STAT_OVF]), 32'h0);
        check("ovf_clr_level",  32'(lvl()), 32'd4);

        // Push lands on the same edge the FSM pops from IDLE
        wait_falls(1, "pf_fall_timeout");
        f = fall_q[0];
        k = 0;
        while (cyc < f + HOLD + CMDW && k < 100) begin
            step();
            k++;
        end
        check("pf_pre_level", 32'(lvl()), 32'd4);
        push(1'b1, 8'hA6);
        check("pf_level",   32'(lvl()), 32'd4);
        check("pf_no_ovf",  32'(status[STAT_OVF]), 32'h0);
        check("pf_popped",  32'({lcd_rs, lcd_data}), 32'h1A1);
        wait_idle("pf_idle_timeout");
        check("pf_count", 32'(data_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("pf_order%0d", i), 32'(data_q[i]), 32'(exp_q[i]));
        check("pf_ovf_final", 32'(status[STAT_OVF]), 32'h0);

        // Reset during the EN pulse must drop EN without a clock edge and flush the FIFO
        ctrl(9'h001);
        push(1'b1, 8'h55);
        push(1'b1, 8'h56);
        push(1'b1, 8'h57);
        k = 0;
        while (!lcd_en && k < 50) begin
            step();
            k++;
        end
        check("mid_en_high", 32'(lcd_en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_en_async", 32'(lcd_en), 32'h0);
        check("mid_status",   status,      32'h0);
        step();
        step();
        rst_n = 1'b1;
        nr = rise_q.size();
        repeat (60) step();
        check("mid_level",    32'(lvl()), 32'd0);
        check("mid_no_pulse", 32'(rise_q.size()), 32'(nr));
        check("mid_en_low",   32'(lcd_en), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
